// File: rtl/prod_result_buffer_if.sv
// prod_result_buffer_if: handshake and status bundle for the product result buffer
// master: producer/consumer side, drives in_valid/mode/product/clear/rd_req
// slave : buffer side, drives in_ready/rd_valid/rd_data/count/full/empty/overflow/checksum
interface prod_result_buffer_if #(
   parameter int DEPTH = 32,
   parameter int AW    = 5
);
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    mode;
   logic [31:0]   product;
   logic          clear;
   logic          rd_req;
   logic          rd_valid;
   logic [31:0]   rd_data;
   logic [AW:0]   count;
   logic          full;
   logic          empty;
   logic          overflow;
   logic [31:0]   checksum;
   modport master (
      output in_valid, mode, product, clear, rd_req,
      input  in_ready, rd_valid, rd_data, count, full, empty, overflow, checksum
   );
   modport slave (
      input  in_valid, mode, product, clear, rd_req,
      output in_ready, rd_valid, rd_data, count, full, empty, overflow, checksum
   );
endinterface

// File: rtl/prod_result_buffer.sv
// prod_result_buffer: normalising 32-entry circular FIFO for multiplier products
// clk_i  : rising-edge clock
// rst_ni : asynchronous active-low reset (pointers, status and outputs only; memory is not reset)
// bus    : prod_result_buffer_if.slave (write handshake, clear, registered read port, status)
// Optional PROD_CHECKSUM_EN: running modulo-2^32 sum of accepted words on bus.checksum
module prod_result_buffer #(
   parameter int DEPTH = 32,
   parameter int AW    = 5
) (
   input logic                 clk_i,
   input logic                 rst_ni,
   prod_result_buffer_if.slave bus
);
   logic [31:0]   mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [AW:0]   count_q, count_d;
   logic          rd_valid_q, rd_valid_d, ovf_q, ovf_d;
   logic [31:0]   rd_data_q, rd_data_d, norm;
   logic          full, empty, wr_en, rd_en;

   assign full  = count_q == (AW+1)'(DEPTH);
   assign empty = count_q == '0;
   // clear wins over both transfers in the same cycle
   assign wr_en = bus.in_valid && !full && !bus.clear;
   assign rd_en = bus.rd_req && !empty && !bus.clear;

   // mode 3 falls through to the unsigned 8x8 form
   always_comb begin
      norm = bus.mode == 2'd2 ? bus.product :
             bus.mode == 2'd1 ? {{16{bus.product[15]}}, bus.product[15:0]} :
                                {16'h0, bus.product[15:0]};
   end

   always_comb begin
      wr_ptr_d   = bus.clear ? '0 : wr_en ? wr_ptr_q + AW'(1) : wr_ptr_q;
      rd_ptr_d   = bus.clear ? '0 : rd_en ? rd_ptr_q + AW'(1) : rd_ptr_q;
      count_d    = bus.clear ? '0 : count_q + (AW+1)'(wr_en) - (AW+1)'(rd_en);
      ovf_d      = bus.clear ? 1'b0 : ovf_q | (bus.in_valid & full);
      rd_valid_d = rd_en;
      rd_data_d  = rd_en ? mem_q[rd_ptr_q] : rd_data_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         ovf_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         ovf_q      <= ovf_d;
         rd_valid_q <= rd_valid_d;
         rd_data_q  <= rd_data_d;
      end
   end

   always_ff @(posedge clk_i) begin
      if (wr_en) mem_q[wr_ptr_q] <= norm;
   end

`ifdef PROD_CHECKSUM_EN
   logic [31:0] chk_q, chk_d;

   always_comb begin
      chk_d = bus.clear ? '0 : wr_en ? chk_q + norm : chk_q;
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) chk_q <= '0;
      else         chk_q <= chk_d;
   end

   assign bus.checksum = chk_q;
`else
   assign bus.checksum = 32'h0;
`endif

   assign bus.in_ready = !full;
   assign bus.full     = full;
   assign bus.empty    = empty;
   assign bus.count    = count_q;
   assign bus.overflow = ovf_q;
   assign bus.rd_valid = rd_valid_q;
   assign bus.rd_data  = rd_data_q;
endmodule

// File: tb/tb_prod_result_buffer.sv
// tb_prod_result_buffer: scoreboard bench against a queue model of the product buffer
module tb_prod_result_buffer;
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   prod_result_buffer_if bus ();
   prod_result_buffer dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));

   int checks = 0;
   int errors = 0;
   logic [31:0] mq [$];
   logic [31:0] sb [$];
   logic        ovf_m = 1'b0;
   logic        rv_m = 1'b0;
   logic [31:0] chk_m = 32'h0;
   logic [31:0] last_m = 32'h0;

   function automatic logic [31:0] nrm(logic [1:0] m, logic [31:0] p);
      logic signed [15:0] s;
      s = p[15:0];
      case (m)
         2'd1:    return 32'(s);
         2'd2:    return p;
         default: return {16'h0, p[15:0]};
      endcase
   endfunction

   task automatic chk(string n, logic [31:0] a, logic [31:0] e);
      checks++;
      if (a !== e) begin
         errors++;
         $display("FAIL %s actual %h required %h at %0t", n, a, e, $time);
      end
   endtask

   always @(negedge clk) begin
      chk("rd_valid", 32'(bus.rd_valid), 32'(rv_m));
      if (bus.rd_valid) begin
         chk("sb_nonempty", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) chk("rd_data", bus.rd_data, sb.pop_front());
      end else begin
         chk("rd_data_hold", bus.rd_data, last_m);
      end
      chk("count", 32'(bus.count), 32'(mq.size()));
      chk("full", 32'(bus.full), 32'(mq.size() == 32));
      chk("empty", 32'(bus.empty), 32'(mq.size() == 0));
      chk("in_ready", 32'(bus.in_ready), 32'(mq.size() != 32));
      chk("overflow", 32'(bus.overflow), 32'(ovf_m));
      chk("checksum", bus.checksum, chk_m);
   end

   task automatic step(logic v, logic [1:0] m, logic [31:0] p, logic c, logic r);
      logic aw, ar, full_m;
      bus.in_valid = v;
      bus.mode     = m;
      bus.product  = p;
      bus.clear    = c;
      bus.rd_req   = r;
      full_m = mq.size() == 32;
      aw = v && !full_m && !c;
      ar = r && mq.size() > 0 && !c;
      @(posedge clk);
      #1;
      if (c) begin
         mq.delete();
         ovf_m = 1'b0;
         chk_m = 32'h0;
         rv_m  = 1'b0;
      end else begin
         if (v && full_m) ovf_m = 1'b1;
         rv_m = ar;
         if (ar) begin
            last_m = mq.pop_front();
            sb.push_back(last_m);
         end
         if (aw) begin
            mq.push_back(nrm(m, p));
`ifdef PROD_CHECKSUM_EN
            chk_m = chk_m + nrm(m, p);
`endif
         end
      end
   endtask

   task automatic idle();
      step(1'b0, 2'd0, 32'h0, 1'b0, 1'b0);
   endtask

   task automatic drain();
      while (mq.size() > 0) step(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);
      idle();
   endtask

   initial begin
      bus.in_valid = 1'b0;
      bus.mode     = 2'd0;
      bus.product  = 32'h0;
      bus.clear    = 1'b0;
      bus.rd_req   = 1'b0;
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      idle();

      for (int m = 0; m < 4; m++) step(1'b1, 2'(m), 32'h0000_FF01, 1'b0, 1'b0);
      drain();

      for (int i = 1; i <= 33; i++) step(1'b1, 2'd3, 32'(i), 1'b0, 1'b0);
      step(1'b1, 2'd0, 32'h55, 1'b0, 1'b1);
      drain();
      step(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);

      for (int i = 0; i < 20; i++) step(1'b1, 2'd2, $urandom, 1'b0, 1'b0);
      drain();
      for (int i = 100; i < 120; i++) step(1'b1, 2'd2, 32'(i), 1'b0, 1'b0);
      drain();

      for (int i = 0; i < 5; i++) step(1'b1, 2'd1, $urandom, 1'b0, 1'b0);
      for (int i = 0; i < 10; i++) step(1'b1, 2'($urandom_range(0, 3)), $urandom, 1'b0, 1'b1);
      drain();

      for (int i = 0; i < 3; i++) step(1'b0, 2'd0, 32'h0, 1'b0, 1'b1);

      step(1'b1, 2'd2, 32'h0000_0010, 1'b0, 1'b0);
      step(1'b1, 2'd2, 32'hFFFF_FFF0, 1'b0, 1'b0);
      idle();
      step(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
      idle();

      for (int i = 0; i < 600; i++) begin
         int rw;
         rw = i < 200 ? 3 : i < 400 ? 1 : 2;
         step($urandom_range(0, 3) < rw, 2'($urandom_range(0, 3)), $urandom,
              $urandom_range(0, 59) == 0, $urandom_range(0, 3) >= rw);
      end
      drain();

      step(1'b0, 2'd0, 32'h0, 1'b1, 1'b0);
      for (int i = 0; i < 7; i++) step(1'b1, 2'd0, $urandom, 1'b0, 1'b0);
      bus.in_valid = 1'b1;
      #2 rst_n = 1'b0;
      #1;
      chk("rst_count", 32'(bus.count), 32'd0);
      chk("rst_empty", 32'(bus.empty), 32'd1);
      chk("rst_rd_valid", 32'(bus.rd_valid), 32'd0);
      chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
      mq.delete();
      sb.delete();
      ovf_m  = 1'b0;
      chk_m  = 32'h0;
      rv_m   = 1'b0;
      last_m = 32'h0;
      bus.in_valid = 1'b0;
      @(posedge clk);
      #1 rst_n = 1'b1;
      for (int i = 0; i < 4; i++) step(1'b1, 2'd1, $urandom, 1'b0, 1'b1);
      drain();
      idle();
      chk("sb_drained", 32'(sb.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/prod_result_buffer.md
# prod_result_buffer

Circular result buffer that sits downstream of the multiplier controller. It accepts one product per handshake, tagged with its multiply mode. It normalises the product to a 32-bit two's-complement or unsigned word according to that mode and stores it in a 32-entry register-file FIFO. It then returns entries in order through a registered read port, and tracks fill level and a sticky overflow flag.

## Interface
Parameters:
- DEPTH, 32, number of stored entries; power of two.
- AW, 5, pointer width, log2(DEPTH).

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  product and mode are valid this cycle.
- in_ready  out  1  buffer can accept; equals !full.
- mode  in  2  encoding of the product:
  - 0 = M1, unsigned 8x8.
  - 1 = M2, signed 8x8.
  - 2 = M3, signed 16x16.
  - 3 = M4, treated as M1.
- product  in  32  raw multiplier output; bits [31:16] are don't-care for M1, M2 and M4.
- clear  in  1  synchronous flush of the pointers, count and overflow flag.
- rd_req  in  1  request to pop the oldest entry.
- rd_valid  out  1  rd_data holds a popped entry this cycle.
- rd_data  out  32  popped normalised entry.
- count  out  AW+1  number of stored entries, 0..DEPTH.
- full  out  1  count == DEPTH.
- empty  out  1  count == 0.
- overflow  out  1  sticky: a product was offered while full.
- checksum  out  32  running sum; see Configuration.

## Operation
- Normalisation, applied before storage:
  - M1 and M4 store {16'h0, product[15:0]}.
  - M2 stores {{16{product[15]}}, product[15:0]}.
  - M3 stores product[31:0] unchanged.
- Write: when in_valid && in_ready, store the normalised word at wr_ptr, then increment wr_ptr modulo DEPTH.
- Read: when rd_req && !empty, register mem[rd_ptr] into rd_data, assert rd_valid on the next cycle, then increment rd_ptr modulo DEPTH.
- Read while empty: the request is ignored, rd_valid stays 0 and rd_data holds its previous value.
- Write while full: data is dropped, overflow is set to 1 and stays set until clear or reset.
- Simultaneous accepted write and accepted read: both happen and count is unchanged.
- Full with simultaneous write and read: the read pops, but the write is still refused because in_ready is 0 that cycle.
- Pointer wrap-around: pointers wrap from DEPTH-1 to 0; count distinguishes full from empty.
- clear has priority over a read or write in the same cycle:
  - The pointers, count and overflow go to 0.
  - rd_valid goes to 0.
  - Memory contents are not erased.
- Memory has no reset; only the pointers and outputs are reset.

## Timing
- Reset values:
  - in_ready = 1.
  - rd_valid = 0.
  - rd_data = 0.
  - count = 0.
  - full = 0.
  - empty = 1.
  - overflow = 0.
  - checksum = 0.
  - wr_ptr and rd_ptr = 0.
- Reset is asynchronous: assertion at any time, including mid-burst, returns every output to these values immediately.
- Accept to readable: a write at edge N is visible to a rd_req sampled at edge N+1, so the minimum store-to-pop latency is 1 cycle.
- Read latency: rd_req sampled at edge N gives rd_valid = 1 and rd_data valid after edge N. rd_valid is a single-cycle pulse per accepted request.
- Back-to-back reads are allowed: one entry per cycle while the buffer is not empty.
- count, full, empty and in_ready update on the same edge as the accepted transfer. They are registered or derived from the registered count, with no combinational path from in_valid or rd_req.

## Configuration
- PROD_CHECKSUM_EN, when defined:
  - checksum is a 32-bit register, modulo 2^32.
  - It adds each accepted normalised word on the edge of acceptance.
  - Dropped (overflow) writes are not added.
  - clear and reset zero it.
- Without PROD_CHECKSUM_EN: checksum is tied to 32'h0 and no adder is built.

## Test plan
- Mode normalisation: write product 32'h0000_FF01 in each of modes 0, 1, 2 and 3, then pop all four. rd_data must be:
  - 32'h0000FF01 for mode 0.
  - 32'hFFFFFF01 for mode 1.
  - 32'h0000FF01 for mode 2.
  - 32'h0000FF01 for mode 3.
- Fill and overflow: write 33 products with values 1..33. After 32 writes, full = 1, in_ready = 0 and count = 32. The 33rd write sets overflow = 1, and popping all entries returns 1..32 in order.
- Wrap-around: write 20 entries and pop 20, then write 20 more (values 100..119) and pop them. rd_data must be 100..119, and empty = 1 at the end.
- Simultaneous operation: with count = 5, assert a write and rd_req together for 10 cycles. count must stay 5 throughout, and rd_valid must pulse every cycle.
- Empty read: rd_req with count = 0 must give rd_valid = 0 and leave rd_data unchanged. Reset asserted mid-burst with count = 7 must immediately give count = 0, empty = 1 and rd_valid = 0.
- With PROD_CHECKSUM_EN: write 32'h0000_0010 and 32'hFFFF_FFF0 in mode 2. checksum must read 32'h0000_0000, and clear must keep it at 0.
